pc_sequencer: RTL

Next-PC controller for the single-cycle core. Each cycle it chooses the value the PC register captures: sequential, branch, jump, register-jump, exception vector, or hold. It arbitrates simultaneous redirect requests and remembers a redirect that arrives during a stall. It also runs a RUN/STALL/HALT state machine and a retired-instruction counter. It drives the PC register's `coming_pc` input directly and reads back the current PC.

---
 rtl/pc_sequencer.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Next-PC selection for the single-cycle core: sequential/branch/jump/register-jump/exception
// targets, redirect capture across stalls, RUN/STALL/HALT control and a retired-instruction count.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] cur_pc,
  input  logic        stall,
  input  logic        halt,
  input  logic        resume,
  input  logic        br_taken,
  input  logic [31:0] br_offset,
  input  logic        jmp,
  input  logic [25:0] jmp_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        exc,
  output logic [31:0] coming_pc,
  output logic [2:0]  pc_src,
  output logic [1:0]  state,
  output logic [31:0] retired,
  output logic        misaligned
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    SRC_SEQ  = 3'd0,
    SRC_BR   = 3'd1,
    SRC_JMP  = 3'd2,
    SRC_JR   = 3'd3,
    SRC_EXC  = 3'd4,
    SRC_HOLD = 3'd5,
    SRC_PEND = 3'd6
  } src_e;

  state_e      state_q, state_d;
  logic        pend_valid_q, pend_valid_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  src_e        pend_src_q, pend_src_d;
  logic [31:0] retired_q, retired_d;
  logic        misaligned_q, misaligned_d;

  logic [31:0] seq_pc;
  logic [31:0] br_pc;
  logic [31:0] jmp_pc;
  logic [31:0] jr_pc;
  logic        jr_mis;
  logic        redir_valid;
  src_e        redir_src;
  logic [31:0] redir_pc;
  logic [31:0] redir_raw;
  logic [31:0] pend_target;
  logic        pend_mis;

  assign seq_pc  = cur_pc + 32'd4;
  assign br_pc   = seq_pc + (br_offset << 2);
  assign jmp_pc  = {seq_pc[31:28], jmp_index, 2'b00};
  assign jr_pc   = {jr_target[31:2], 2'b00};
  assign jr_mis  = |jr_target[1:0];

  assign redir_valid = jr | jmp | br_taken;

  always_comb begin
    redir_src = SRC_SEQ;
    redir_pc  = seq_pc;
    if (jr) begin
      redir_src = SRC_JR;
      redir_pc  = jr_pc;
    end else if (jmp) begin
      redir_src = SRC_JMP;
      redir_pc  = jmp_pc;
    end else if (br_taken) begin
      redir_src = SRC_BR;
      redir_pc  = br_pc;
    end
  end

  // A latched jr keeps its raw low bits so misalignment is flagged only when it is applied.
  assign redir_raw   = jr ? jr_target : redir_pc;
  assign pend_target = (pend_src_q == SRC_JR) ? {pend_pc_q[31:2], 2'b00} : pend_pc_q;
  assign pend_mis    = (pend_src_q == SRC_JR) && (|pend_pc_q[1:0]);

  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    pend_src_d   = pend_src_q;
    retired_d    = retired_q;
    misaligned_d = misaligned_q;
    coming_pc    = cur_pc;
    pc_src       = SRC_HOLD;

    if (RESET) begin
      coming_pc = RESET_VECTOR;
    end else if (exc) begin
      coming_pc    = EXC_VECTOR;
      pc_src       = SRC_EXC;
      state_d      = ST_RUN;
      pend_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (stall) begin
            state_d = ST_STALL;
            if (redir_valid) begin
              pend_valid_d = 1'b1;
              pend_pc_d    = redir_raw;
              pend_src_d   = redir_src;
            end
          end else if (halt) begin
            state_d = ST_HALT;
          end else begin
            coming_pc = redir_pc;
            pc_src    = redir_src;
            retired_d = retired_q + 32'd1;
            if (jr && jr_mis) misaligned_d = 1'b1;
          end
        end

        ST_STALL: begin
          if (stall) begin
            if (!pend_valid_q && redir_valid) begin
              pend_valid_d = 1'b1;
              pend_pc_d    = redir_raw;
              pend_src_d   = redir_src;
            end
          end else begin
            state_d   = ST_RUN;
            retired_d = retired_q + 32'd1;
            if (pend_valid_q) begin
              coming_pc    = pend_target;
              pc_src       = SRC_PEND;
              pend_valid_d = 1'b0;
              if (pend_mis) misaligned_d = 1'b1;
            end else begin
              coming_pc = redir_pc;
              pc_src    = redir_src;
              if (jr && jr_mis) misaligned_d = 1'b1;
            end
          end
        end

        ST_HALT: begin
          if (resume) begin
            coming_pc = seq_pc;
            pc_src    = SRC_SEQ;
            retired_d = retired_q + 32'd1;
            state_d   = ST_RUN;
          end
        end

        default: begin
          state_d = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(negedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= ST_RUN;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
      pend_src_q   <= SRC_SEQ;
      retired_q    <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      pend_src_q   <= pend_src_d;
      retired_q    <= retired_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign state      = state_q;
  assign retired    = retired_q;
  assign misaligned = misaligned_q;

endmodule
